// File: rtl/pipeline_stage_elastic.sv
// Elastic pipeline register carrying PC and instruction between two stages.
// Adds a valid/ready handshake, an optional 2-entry skid buffer, a
// synchronous flush that leaves a bubble (NOP), and a saturating stall counter.
//
// Ports:
//   clock, reset        single clock; asynchronous active-high reset
//   in_valid/in_ready   upstream handshake (in_ready is a flop when SKID=1)
//   pc_in, instr_in     upstream payload
//   flush               synchronous kill of held entries and of this cycle's input
//   out_valid/out_ready downstream handshake
//   pc_out, instr_out   registered payload; 0/NOP while out_valid=0
//   stall_count         saturating count of out_valid & ~out_ready & ~flush cycles
module pipeline_stage_elastic #(
  parameter int unsigned        PC_W    = 32,
  parameter int unsigned        INSTR_W = 32,
  parameter logic [INSTR_W-1:0] NOP     = 32'h00000013,
  parameter bit                 SKID    = 1'b1,
  parameter int unsigned        STALL_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    pc_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic [STALL_W-1:0] stall_count
);

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

  state_t             state, state_nxt;
  logic [PC_W-1:0]    main_pc, main_pc_nxt, skid_pc, skid_pc_nxt;
  logic [INSTR_W-1:0] main_instr, main_instr_nxt, skid_instr, skid_instr_nxt;
  logic               valid_q, ready_q;
  logic [STALL_W-1:0] stall_q;
  logic               in_xfer, out_xfer;

  // State and datapath registers. valid/ready flags are registered from the
  // next state so neither output has a combinational path from out_ready
  // (when SKID=1). Entries are cleared when vacated, so the payload outputs
  // read 0/NOP directly from the flops whenever the stage is empty.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= EMPTY;
      main_pc    <= '0;
      main_instr <= NOP;
      skid_pc    <= '0;
      skid_instr <= NOP;
      valid_q    <= 1'b0;
      ready_q    <= 1'b1;
      stall_q    <= '0;
    end else begin
      state      <= state_nxt;
      main_pc    <= main_pc_nxt;
      main_instr <= main_instr_nxt;
      skid_pc    <= skid_pc_nxt;
      skid_instr <= skid_instr_nxt;
      valid_q    <= (state_nxt != EMPTY);
      ready_q    <= (state_nxt != FULL);
      if (valid_q && !out_ready && !flush && (stall_q != '1))
        stall_q <= stall_q + 1'b1;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt      = state;
    main_pc_nxt    = main_pc;
    main_instr_nxt = main_instr;
    skid_pc_nxt    = skid_pc;
    skid_instr_nxt = skid_instr;
    in_xfer        = in_valid & in_ready;
    out_xfer       = valid_q & out_ready;
    if (flush) begin
      state_nxt      = EMPTY;
      main_pc_nxt    = '0;
      main_instr_nxt = NOP;
      skid_pc_nxt    = '0;
      skid_instr_nxt = NOP;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_xfer) begin
            main_pc_nxt    = pc_in;
            main_instr_nxt = instr_in;
            state_nxt      = BUSY;
          end
        end
        BUSY: begin
          if (in_xfer && out_xfer) begin
            main_pc_nxt    = pc_in;
            main_instr_nxt = instr_in;
          end else if (in_xfer) begin
            // Only reachable with SKID=1: in_ready is combinationally low
            // otherwise whenever out_ready=0 in BUSY.
            skid_pc_nxt    = pc_in;
            skid_instr_nxt = instr_in;
            state_nxt      = FULL;
          end else if (out_xfer) begin
            main_pc_nxt    = '0;
            main_instr_nxt = NOP;
            state_nxt      = EMPTY;
          end
        end
        FULL: begin
          if (out_ready) begin
            main_pc_nxt    = skid_pc;
            main_instr_nxt = skid_instr;
            skid_pc_nxt    = '0;
            skid_instr_nxt = NOP;
            state_nxt      = BUSY;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Outputs.
  always_comb begin
    in_ready    = SKID ? ready_q : (~valid_q | out_ready);
    out_valid   = valid_q;
    pc_out      = main_pc;
    instr_out   = main_instr;
    stall_count = stall_q;
  end

endmodule

// File: tb/tb_pipeline_stage_elastic.sv
// Drives three instances (SKID=1, SKID=0, SKID=1 with a 4-bit stall counter)
// from shared stimulus and compares each against a bounded-FIFO model.
module tb_pipeline_stage_elastic;

  localparam logic [31:0] NOPV = 32'h00000013;

  logic        clock = 1'b0;
  logic        reset, in_valid, flush, out_ready;
  logic [31:0] pc_in, instr_in;

  logic [2:0]  rdy, ov;
  logic [31:0] pco [3];
  logic [31:0] ino [3];
  logic [15:0] sc0, sc1;
  logic [3:0]  sc2;

  int unsigned total = 0, passed = 0, failed = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mem  [3][2];
  int unsigned occ  [3] = '{0, 0, 0};
  int unsigned stl  [3] = '{0, 0, 0};
  int unsigned smax [3] = '{65535, 65535, 15};
  bit          skidp[3] = '{1'b1, 1'b0, 1'b1};

  always #5 clock = ~clock;

  pipeline_stage_elastic #(.PC_W(32), .INSTR_W(32), .NOP(NOPV), .SKID(1'b1), .STALL_W(16)) dut0 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]), .pc_in(pc_in),
    .instr_in(instr_in), .flush(flush), .out_valid(ov[0]), .out_ready(out_ready),
    .pc_out(pco[0]), .instr_out(ino[0]), .stall_count(sc0));

  pipeline_stage_elastic #(.PC_W(32), .INSTR_W(32), .NOP(NOPV), .SKID(1'b0), .STALL_W(16)) dut1 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]), .pc_in(pc_in),
    .instr_in(instr_in), .flush(flush), .out_valid(ov[1]), .out_ready(out_ready),
    .pc_out(pco[1]), .instr_out(ino[1]), .stall_count(sc1));

  pipeline_stage_elastic #(.PC_W(32), .INSTR_W(32), .NOP(NOPV), .SKID(1'b1), .STALL_W(4)) dut2 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy[2]), .pc_in(pc_in),
    .instr_in(instr_in), .flush(flush), .out_valid(ov[2]), .out_ready(out_ready),
    .pc_out(pco[2]), .instr_out(ino[2]), .stall_count(sc2));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_ready(input int d);
    if (skidp[d]) return occ[d] < 2;
    return (occ[d] == 0) || out_ready;
  endfunction

  function automatic logic [63:0] stall_of(input int d);
    case (d)
      0:       return 64'(sc0);
      1:       return 64'(sc1);
      default: return 64'(sc2);
    endcase
  endfunction

  task automatic check_outputs(input string phase);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s_valid%0d", phase, d), 64'(ov[d]), 64'(occ[d] > 0));
      check($sformatf("%s_pc%0d", phase, d), 64'(pco[d]), (occ[d] > 0) ? 64'(mem[d][0].pc) : 64'd0);
      check($sformatf("%s_instr%0d", phase, d), 64'(ino[d]), (occ[d] > 0) ? 64'(mem[d][0].instr) : 64'(NOPV));
      check($sformatf("%s_stall%0d", phase, d), stall_of(d), 64'(stl[d]));
    end
  endtask

  // One clock cycle: drive, check in_ready before the edge, advance the
  // model at the edge, check the registered outputs after it.
  task automatic step(input bit iv, input logic [31:0] pc, input logic [31:0] ins,
                      input bit ordy, input bit fl);
    bit xin [3];
    bit xout[3];
    in_valid  = iv;
    pc_in     = pc;
    instr_in  = ins;
    out_ready = ordy;
    flush     = fl;
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("in_ready%0d", d), 64'(rdy[d]), 64'(exp_ready(d)));
      xin[d]  = iv && exp_ready(d);
      xout[d] = (occ[d] > 0) && ordy;
    end
    @(posedge clock);
    #1;
    for (int d = 0; d < 3; d++) begin
      if ((occ[d] > 0) && !ordy && !fl && (stl[d] < smax[d])) stl[d]++;
      if (fl) occ[d] = 0;
      else begin
        if (xout[d]) begin
          mem[d][0] = mem[d][1];
          occ[d]--;
        end
        if (xin[d]) begin
          mem[d][occ[d]] = '{pc: pc, instr: ins};
          occ[d]++;
        end
      end
    end
    check_outputs("cyc");
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      occ[d] = 0;
      stl[d] = 0;
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    pc_in = '0; instr_in = '0;
    repeat (2) @(posedge clock);
    #1;
    model_reset();
    check_outputs("reset");
    for (int d = 0; d < 3; d++) check($sformatf("reset_rdy%0d", d), 64'(rdy[d]), 64'd1);
    reset = 1'b0;

    // Streaming pass-through with out_ready held high.
    for (int i = 0; i < 8; i++) step(1'b1, 32'(i * 4), 32'h1000_0000 + 32'(i), 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Backpressure: out_ready drops for 3 cycles once 0x100 is at the output.
    step(1'b1, 32'h100, 32'hA100, 1'b1, 1'b0);
    step(1'b1, 32'h104, 32'hA104, 1'b0, 1'b0);
    step(1'b1, 32'h108, 32'hA108, 1'b0, 1'b0);
    step(1'b1, 32'h108, 32'hA108, 1'b0, 1'b0);
    check("bp_stall3", 64'(sc0), 64'd3);
    check("bp_held", 64'(pco[0]), 64'h100);
    check("bp_full", 64'(rdy[0]), 64'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h108, 32'hA108, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Fill to FULL, then flush with an input offered in the same cycle.
    step(1'b1, 32'h1F0, 32'hB1F0, 1'b0, 1'b0);
    step(1'b1, 32'h1F4, 32'hB1F4, 1'b0, 1'b0);
    step(1'b1, 32'h200, 32'hB200, 1'b0, 1'b1);
    check("flush_pc", 64'(pco[0]), 64'd0);
    check("flush_nop", 64'(ino[0]), 64'(NOPV));
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1, 1'b0);

    // Stall saturation on the 4-bit counter, then a flush that is not counted.
    step(1'b1, 32'h300, 32'hC300, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
    check("sat_15", 64'(sc2), 64'd15);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, $urandom, $urandom,
           $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);

    // Asynchronous reset while dut0 is FULL, checked before the next edge.
    step(1'b1, 32'h400, 32'hD400, 1'b0, 1'b0);
    step(1'b1, 32'h404, 32'hD404, 1'b0, 1'b0);
    step(1'b1, 32'h408, 32'hD408, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs("areset");
    for (int d = 0; d < 3; d++) check($sformatf("areset_rdy%0d", d), 64'(rdy[d]), 64'd1);
    #2;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, 32'h500 + 32'(i * 4), 32'hE000 + 32'(i), 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
